// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP register back-end.
// One-hot TAP states, DR select codes and helper functions.
package jtag_pkg;

  localparam logic [15:0] ST_TLR   = 16'h0001;
  localparam logic [15:0] ST_RTI   = 16'h0002;
  localparam logic [15:0] ST_SELDR = 16'h0004;
  localparam logic [15:0] ST_CAPDR = 16'h0008;
  localparam logic [15:0] ST_SHDR  = 16'h0010;
  localparam logic [15:0] ST_EX1DR = 16'h0020;
  localparam logic [15:0] ST_PAUDR = 16'h0040;
  localparam logic [15:0] ST_EX2DR = 16'h0080;
  localparam logic [15:0] ST_UPDDR = 16'h0100;
  localparam logic [15:0] ST_SELIR = 16'h0200;
  localparam logic [15:0] ST_CAPIR = 16'h0400;
  localparam logic [15:0] ST_SHIR  = 16'h0800;
  localparam logic [15:0] ST_EX1IR = 16'h1000;
  localparam logic [15:0] ST_PAUIR = 16'h2000;
  localparam logic [15:0] ST_EX2IR = 16'h4000;
  localparam logic [15:0] ST_UPDIR = 16'h8000;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

  // IR capture pattern: ...0001, low two bits 2'b01.
  function automatic logic [31:0] ir_cap_pat(
    input int w
  );
    logic [31:0] p;
    p = '0;
    if (w > 0) p[0] = 1'b1;
    return p;
  endfunction

  // BYPASS opcode is all ones over the IR width.
  function automatic logic [31:0] bypass_opc(
    input int w
  );
    if (w >= 32) return '1;
    return (32'h1 << w) - 32'h1;
  endfunction

endpackage

// File: rtl/jtag_tap_regs_if.sv
// Bundle between the TAP controller side and the register back-end.
// master drives state/data in, slave drives serial and parallel outs.
interface jtag_tap_regs_if #(
  parameter int IR_WIDTH   = 4,
  parameter int USER_WIDTH = 16
);
  logic [15:0]           tap_state;
  logic                  tdi;
  logic [USER_WIDTH-1:0] user_din;
  logic                  tdo;
  logic                  tdo_en;
  logic [IR_WIDTH-1:0]   ir_q;
  logic [USER_WIDTH-1:0] user_dout;
  logic                  user_upd;

  modport master (
    output tap_state, tdi, user_din,
    input  tdo, tdo_en, ir_q,
    input  user_dout, user_upd
  );

  modport slave (
    input  tap_state, tdi, user_din,
    output tdo, tdo_en, ir_q,
    output user_dout, user_upd
  );
endinterface

// File: rtl/jtag_shift_reg.sv
// Generic capture/shift/update register, LSB out first.
// upd_rst reloads the update latch with its reset value.
module jtag_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] SH_RST  = '0,
  parameter logic [WIDTH-1:0] UPD_RST = '0
) (
  input  logic             tck,
  input  logic             trst_n,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             upd_rst,
  input  logic [WIDTH-1:0] cap_val,
  input  logic             tdi,
  output logic             so,
  output logic [WIDTH-1:0] pout
);

  logic [WIDTH-1:0] sr;

  // Shift stage: capture parallel value or shift tdi into MSB.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) sr <= SH_RST;
    else if (capture) sr <= cap_val;
    else if (shift) sr <= {tdi, sr[WIDTH-1:1]};
  end

  // Update latch: only changes on update or forced reload.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) pout <= UPD_RST;
    else if (upd_rst) pout <= UPD_RST;
    else if (update) pout <= sr;
  end

  assign so = sr[0];

endmodule

// File: rtl/jtag_tap_regs.sv
// JTAG TAP register back-end: IR, BYPASS, IDCODE, USER.
// TDO and its enable are retimed on the falling edge of tck.
module jtag_tap_regs
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPC = 4'h1,
  parameter logic [IR_WIDTH-1:0] USER_OPC = 4'h8,
  parameter int USER_WIDTH = 16
) (
  input logic tck,
  input logic trst_n,
  jtag_tap_regs_if.slave bus
);

  localparam logic [31:0] IR_CAP32 = ir_cap_pat(IR_WIDTH);
  localparam logic [IR_WIDTH-1:0] IR_CAP =
    IR_CAP32[IR_WIDTH-1:0];

  // Exact compares make zero or multi-hot states a no-op.
  logic st_tlr, st_capdr, st_shdr, st_upddr;
  logic st_capir, st_shir, st_updir;
  assign st_tlr   = bus.tap_state == ST_TLR;
  assign st_capdr = bus.tap_state == ST_CAPDR;
  assign st_shdr  = bus.tap_state == ST_SHDR;
  assign st_upddr = bus.tap_state == ST_UPDDR;
  assign st_capir = bus.tap_state == ST_CAPIR;
  assign st_shir  = bus.tap_state == ST_SHIR;
  assign st_updir = bus.tap_state == ST_UPDIR;

  dr_sel_e sel;
  logic    ir_so, id_so, usr_so, dr_so;
  logic    bypass;

  // DR select from the current instruction.
  always_comb begin
    sel = DR_BYPASS;
    unique case (1'b1)
      (bus.ir_q == IDCODE_OPC): sel = DR_IDCODE;
      (bus.ir_q == USER_OPC):   sel = DR_USER;
      default:                  sel = DR_BYPASS;
    endcase
  end

  logic sel_id, sel_usr, sel_byp;
  assign sel_id  = sel == DR_IDCODE;
  assign sel_usr = sel == DR_USER;
  assign sel_byp = sel == DR_BYPASS;

  jtag_shift_reg #(
    .WIDTH  (IR_WIDTH),
    .SH_RST (IR_CAP),
    .UPD_RST(IDCODE_OPC)
  ) u_ir (
    .tck    (tck),
    .trst_n (trst_n),
    .capture(st_capir),
    .shift  (st_shir),
    .update (st_updir),
    .upd_rst(st_tlr),
    .cap_val(IR_CAP),
    .tdi    (bus.tdi),
    .so     (ir_so),
    .pout   (bus.ir_q)
  );

  jtag_shift_reg #(
    .WIDTH (32),
    .SH_RST(IDCODE_VAL)
  ) u_idcode (
    .tck    (tck),
    .trst_n (trst_n),
    .capture(st_capdr & sel_id),
    .shift  (st_shdr & sel_id),
    .update (1'b0),
    .upd_rst(1'b0),
    .cap_val(IDCODE_VAL),
    .tdi    (bus.tdi),
    .so     (id_so),
    .pout   ()
  );

  jtag_shift_reg #(
    .WIDTH(USER_WIDTH)
  ) u_user (
    .tck    (tck),
    .trst_n (trst_n),
    .capture(st_capdr & sel_usr),
    .shift  (st_shdr & sel_usr),
    .update (st_upddr & sel_usr),
    .upd_rst(1'b0),
    .cap_val(bus.user_din),
    .tdi    (bus.tdi),
    .so     (usr_so),
    .pout   (bus.user_dout)
  );

  // Single-bit BYPASS register.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) bypass <= 1'b0;
    else if (st_capdr & sel_byp) bypass <= 1'b0;
    else if (st_shdr & sel_byp) bypass <= bus.tdi;
  end

  // One-cycle strobe whenever user_dout is written.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) bus.user_upd <= 1'b0;
    else bus.user_upd <= st_upddr & sel_usr;
  end

  // Serial output of the selected DR.
  always_comb begin
    dr_so = bypass;
    unique case (sel)
      DR_IDCODE: dr_so = id_so;
      DR_USER:   dr_so = usr_so;
      default:   dr_so = bypass;
    endcase
  end

  // TDO retimed on falling edge; holds outside shift states.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      bus.tdo    <= 1'b0;
      bus.tdo_en <= 1'b0;
    end else begin
      bus.tdo_en <= st_shir | st_shdr;
      if (st_shir) bus.tdo <= ir_so;
      else if (st_shdr) bus.tdo <= dr_so;
    end
  end

endmodule

// File: tb/tb_jtag_tap_regs.sv
// Directed bench for the JTAG TAP register back-end.
// Walks the TAP states by hand and checks tdo and parallel outs.
module tb_jtag_tap_regs;
  import jtag_pkg::*;

  logic tck = 1'b0;
  logic trst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 tck = ~tck;

  jtag_tap_regs_if #(
    .IR_WIDTH  (4),
    .USER_WIDTH(16)
  ) bus ();

  jtag_tap_regs #(
    .IR_WIDTH  (4),
    .IDCODE_VAL(32'h1234_5679),
    .IDCODE_OPC(4'h1),
    .USER_OPC  (4'h8),
    .USER_WIDTH(16)
  ) u_dut (
    .tck   (tck),
    .trst_n(trst_n),
    .bus   (bus.slave)
  );

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One tck cycle; tdo sampled after the falling edge.
  task automatic step(
    input logic [15:0] st,
    input logic d,
    output logic t,
    output logic e
  );
    bus.tap_state = st;
    bus.tdi = d;
    @(negedge tck);
    #1;
    t = bus.tdo;
    e = bus.tdo_en;
    @(posedge tck);
    #1;
  endtask

  // Full IR or DR scan from RTI, optional break after brk bits.
  task automatic scan(
    input bit ir,
    input int n,
    input logic [31:0] din,
    input int brk,
    input bit bad_st,
    output logic [31:0] dout,
    output logic en_ok,
    output logic u_a,
    output logic u_b
  );
    logic t, e;
    logic [15:0] sh;
    sh = ir ? ST_SHIR : ST_SHDR;
    dout = '0;
    en_ok = 1'b1;
    step(ST_SELDR, 1'b0, t, e);
    if (ir) step(ST_SELIR, 1'b0, t, e);
    step(ir ? ST_CAPIR : ST_CAPDR, 1'b0, t, e);
    for (int i = 0; i < n; i++) begin
      if (brk != 0 && i == brk) begin
        if (bad_st) begin
          repeat (3) begin
            step(16'h0018, 1'b1, t, e);
            en_ok &= !e;
          end
          repeat (2) begin
            step(16'h0000, 1'b1, t, e);
            en_ok &= !e;
          end
        end else begin
          step(ST_EX1DR, 1'b1, t, e);
          en_ok &= !e;
          repeat (5) begin
            step(ST_PAUDR, 1'b1, t, e);
            en_ok &= !e;
          end
          step(ST_EX2DR, 1'b1, t, e);
          en_ok &= !e;
        end
      end
      step(sh, din[i], t, e);
      dout[i] = t;
      en_ok &= e;
    end
    step(ir ? ST_EX1IR : ST_EX1DR, 1'b0, t, e);
    en_ok &= !e;
    step(ir ? ST_UPDIR : ST_UPDDR, 1'b0, t, e);
    u_a = bus.user_upd;
    step(ST_RTI, 1'b0, t, e);
    u_b = bus.user_upd;
  endtask

  logic [31:0] d;
  logic ok, ua, ub, t, e;

  initial begin
    bus.tap_state = ST_TLR;
    bus.tdi = 1'b0;
    bus.user_din = '0;
    #12;
    chk("rst_ir_q", bus.ir_q, 32'h1);
    chk("rst_tdo", bus.tdo, 32'h0);
    chk("rst_tdo_en", bus.tdo_en, 32'h0);
    chk("rst_udout", bus.user_dout, 32'h0);
    chk("rst_uupd", bus.user_upd, 32'h0);
    trst_n = 1'b1;

    step(ST_TLR, 1'b0, t, e);
    step(ST_RTI, 1'b0, t, e);
    scan(0, 32, 32'h0, 0, 0, d, ok, ua, ub);
    chk("id_ir_q", bus.ir_q, 32'h1);
    chk("id_tdo", d, 32'h1234_5679);
    chk("id_en", ok, 32'h1);

    scan(1, 4, 32'hF, 0, 0, d, ok, ua, ub);
    chk("irf_tdo", d, 32'h1);
    chk("irf_en", ok, 32'h1);
    chk("irf_ir_q", bus.ir_q, 32'hF);
    scan(0, 8, 32'hA5, 0, 0, d, ok, ua, ub);
    chk("byp_tdo", d, 32'h4A);
    chk("byp_en", ok, 32'h1);
    chk("byp_upd", ua, 32'h0);

    scan(1, 4, 32'h8, 0, 0, d, ok, ua, ub);
    chk("ir8_ir_q", bus.ir_q, 32'h8);
    bus.user_din = 16'hBEEF;
    scan(0, 16, 32'h1234, 0, 0, d, ok, ua, ub);
    chk("usr_tdo", d, 32'hBEEF);
    chk("usr_en", ok, 32'h1);
    chk("usr_dout", bus.user_dout, 32'h1234);
    chk("usr_upd_hi", ua, 32'h1);
    chk("usr_upd_lo", ub, 32'h0);

    scan(1, 4, 32'h3, 0, 0, d, ok, ua, ub);
    chk("ir3_ir_q", bus.ir_q, 32'h3);
    scan(0, 8, 32'h3C, 0, 0, d, ok, ua, ub);
    chk("ir3_tdo", d, 32'h78);
    chk("ir3_dout", bus.user_dout, 32'h1234);
    chk("ir3_upd_a", ua, 32'h0);
    chk("ir3_upd_b", ub, 32'h0);

    scan(1, 4, 32'h8, 0, 0, d, ok, ua, ub);
    bus.user_din = 16'h5A3C;
    scan(0, 16, 32'h0F1E, 6, 0, d, ok, ua, ub);
    chk("pau_tdo", d, 32'h5A3C);
    chk("pau_en", ok, 32'h1);
    chk("pau_dout", bus.user_dout, 32'h0F1E);
    chk("pau_upd", ua, 32'h1);

    step(ST_SELDR, 1'b0, t, e);
    step(ST_SELIR, 1'b0, t, e);
    step(ST_CAPIR, 1'b0, t, e);
    step(ST_SHIR, 1'b1, t, e);
    chk("pre_rst_en", bus.tdo_en, 32'h1);
    chk("pre_rst_tdo", bus.tdo, 32'h1);
    chk("pre_rst_ir", bus.ir_q, 32'h8);
    #2;
    trst_n = 1'b0;
    #1;
    chk("mid_rst_ir", bus.ir_q, 32'h1);
    chk("mid_rst_tdo", bus.tdo, 32'h0);
    chk("mid_rst_en", bus.tdo_en, 32'h0);
    chk("mid_rst_dout", bus.user_dout, 32'h0);
    bus.tap_state = ST_RTI;
    #3;
    trst_n = 1'b1;
    step(ST_RTI, 1'b0, t, e);
    scan(0, 8, 32'h0, 0, 0, d, ok, ua, ub);
    chk("post_rst_tdo", d, 32'h79);

    scan(1, 4, 32'h8, 0, 0, d, ok, ua, ub);
    scan(0, 16, 32'hCAFE, 0, 0, d, ok, ua, ub);
    chk("tlr_pre_dout", bus.user_dout, 32'hCAFE);
    chk("tlr_pre_ir", bus.ir_q, 32'h8);
    repeat (5) step(ST_TLR, 1'b1, t, e);
    chk("tlr_ir_q", bus.ir_q, 32'h1);
    chk("tlr_dout", bus.user_dout, 32'hCAFE);
    chk("tlr_upd", bus.user_upd, 32'h0);

    step(ST_RTI, 1'b0, t, e);
    scan(0, 32, 32'h0, 4, 1, d, ok, ua, ub);
    chk("ill_tdo", d, 32'h1234_5679);
    chk("ill_en", ok, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
